// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU fixed/floating conversion path.
// Q1.30 sign-magnitude fixed point, FP16 field widths, converter states.
package alu_pkg;
   localparam int FP16_EXP_W   = 5;
   localparam int FP16_MANT_W  = 10;
   localparam int FP16_BIAS    = 15;
   localparam int FIX_W        = 32;
   localparam int FIX_FRAC     = 30;
   localparam int FIX_SUBN_LSB = 6;
   localparam int FIX_MAX_EXP  = 15;
   localparam int CNT_W        = 4;

   localparam logic [FIX_W-2:0] FIX_SAT_MAG = 31'h7FFFFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 classifier: special-value flags and the left-shift
// count that brings a finite mantissa to its Q1.30 position.
module fp16_classify
   import alu_pkg::*;
(
   input  logic [15:0]      float_in,
   output logic             is_nan,
   output logic             is_inf,
   output logic             is_ovf,
   output logic             is_sub,
   output logic [CNT_W-1:0] shift_cnt
);
   logic [FP16_EXP_W-1:0]  e;
   logic [FP16_MANT_W-1:0] m;

   assign e = float_in[14:10];
   assign m = float_in[9:0];

   assign is_nan = (&e) & (|m);
   assign is_inf = (&e) & ~(|m);
   // Finite exponents above the bias give |value| >= 2.0, beyond Q1.30
   assign is_ovf = ~(&e) & (e > 5'(FIX_MAX_EXP));
   assign is_sub = (e == '0);

   // For 1..15 the top exponent bit is clear, so e-1 fits in four bits
   assign shift_cnt = (is_sub || e[4]) ? '0 : (e[3:0] - 4'd1);
endmodule

// File: rtl/float2fix.sv
// FP16 to Q1.30 sign-magnitude converter with an iterative left shifter
// and valid/ready handshakes on both sides.
module float2fix
   import alu_pkg::*;
#(
   parameter int SHIFT_STEP = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] float_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] fixed_out,
   output logic        ovf,
   output logic        nan
);
   localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFT_STEP);

   state_t              state_reg, state_next;
   logic [FIX_W-2:0]    work_reg, work_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                sign_reg, sign_next;
   logic [FIX_W-1:0]    fixed_reg, fixed_next;
   logic                ovf_reg, ovf_next;
   logic                nan_reg, nan_next;
   logic [CNT_W-1:0]    step_amt;

   logic                is_nan, is_inf, is_ovf, is_sub;
   logic [CNT_W-1:0]    shift_cnt;

   fp16_classify u_classify (
      .float_in  (float_in),
      .is_nan    (is_nan),
      .is_inf    (is_inf),
      .is_ovf    (is_ovf),
      .is_sub    (is_sub),
      .shift_cnt (shift_cnt)
   );

   assign step_amt  = (cnt_reg < STEP) ? cnt_reg : STEP;
   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign fixed_out = fixed_reg;
   assign ovf       = ovf_reg;
   assign nan       = nan_reg;

   always_comb begin
      state_next = state_reg;
      work_next  = work_reg;
      cnt_next   = cnt_reg;
      sign_next  = sign_reg;
      fixed_next = fixed_reg;
      ovf_next   = ovf_reg;
      nan_next   = nan_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               sign_next = float_in[15];
               if (is_nan) begin
                  fixed_next = '0;
                  nan_next   = 1'b1;
                  ovf_next   = 1'b0;
                  state_next = DONE;
               end else if (is_inf || is_ovf) begin
                  fixed_next = {float_in[15], FIX_SAT_MAG};
                  ovf_next   = 1'b1;
                  nan_next   = 1'b0;
                  state_next = DONE;
               end else begin
                  // Subnormal LSB (2^-24) sits at bit 6; normals add the hidden one at bit 16
                  work_next  = is_sub ? {15'b0, float_in[9:0], 6'b0}
                                      : {14'b0, 1'b1, float_in[9:0], 6'b0};
                  cnt_next   = shift_cnt;
                  state_next = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (cnt_reg != '0) begin
               work_next = work_reg << step_amt;
               cnt_next  = cnt_reg - step_amt;
            end else begin
               fixed_next = {sign_reg & (|work_reg), work_reg};
               ovf_next   = 1'b0;
               nan_next   = 1'b0;
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         work_reg  <= '0;
         cnt_reg   <= '0;
         sign_reg  <= 1'b0;
         fixed_reg <= '0;
         ovf_reg   <= 1'b0;
         nan_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         work_reg  <= work_next;
         cnt_reg   <= cnt_next;
         sign_reg  <= sign_next;
         fixed_reg <= fixed_next;
         ovf_reg   <= ovf_next;
         nan_reg   <= nan_next;
      end
   end
endmodule

// File: tb/tb_float2fix.sv
// Scoreboard bench: two converters (SHIFT_STEP 1 and 4) share stimulus;
// expected results come from an arithmetic FP16 -> Q1.30 model.
module tb_float2fix;
   typedef struct {
      logic [31:0] fixed;
      logic        ovf;
      logic        nan;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] float_in = '0;
   logic        out_ready = 1'b0;
   logic        hold = 1'b0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic        ir[2];
   logic        ov[2];
   logic        ovf_o[2];
   logic        nan_o[2];
   logic [31:0] fo[2];
   exp_t        q[2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         float2fix #(.SHIFT_STEP(gi == 0 ? 1 : 4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (ir[gi]),
            .float_in  (float_in),
            .out_valid (ov[gi]),
            .out_ready (out_ready),
            .fixed_out (fo[gi]),
            .ovf       (ovf_o[gi]),
            .nan       (nan_o[gi])
         );
      end
   endgenerate

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s inst%0d: got %h, required %h", name, inst, act, req);
      end
   endtask

   // Value = mant * 2^(e-25) for normals, m * 2^-24 for subnormals; scale by 2^30
   function automatic exp_t model(input logic [15:0] f, input int step);
      exp_t r;
      int e = int'(f[14:10]);
      int m = int'(f[9:0]);
      longint mag;
      int cnt;
      r.ovf = 1'b0;
      r.nan = 1'b0;
      r.acc = 0;
      if (e == 31 && m != 0) begin
         r.fixed = 32'h0;
         r.nan   = 1'b1;
         r.lat   = 1;
      end else if (e >= 16) begin
         r.fixed = {f[15], 31'h7FFFFFFF};
         r.ovf   = 1'b1;
         r.lat   = 1;
      end else begin
         mag   = (e == 0) ? longint'(m) * 64 : longint'(1024 + m) << (e + 5);
         cnt   = (e == 0) ? 0 : e - 1;
         r.lat = (cnt + step - 1) / step + 2;
         r.fixed = (mag == 0) ? 32'h0 : {f[15], mag[30:0]};
      end
      return r;
   endfunction

   task automatic issue(input logic [15:0] f);
      int t = 0;
      exp_t x;
      while (!(ir[0] && ir[1]) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got in_ready %b%b, required 11", ir[1], ir[0]);
         return;
      end
      in_valid = 1'b1;
      float_in = f;
      for (int i = 0; i < 2; i++) begin
         x = model(f, i == 0 ? 1 : 4);
         x.acc = cyc;
         q[i].push_back(x);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q[0].size() != 0 || q[1].size() != 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) chk("drain_timeout", 0, 32'(q[0].size() + q[1].size()), 32'h0);
   endtask

   always @(negedge clk) out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);

   generate
      for (gi = 0; gi < 2; gi++) begin : g_mon
         initial begin
            bit          prev_v = 1'b0;
            logic [31:0] held_f;
            logic        held_o, held_n;
            exp_t        x;
            forever begin
               @(negedge clk);
               #1;
               if (rst) begin
                  prev_v = 1'b0;
               end else if (ov[gi]) begin
                  if (!prev_v) begin
                     if (q[gi].size() == 0) begin
                        chk("unexpected_out_valid", gi, 32'h1, 32'h0);
                     end else begin
                        x = q[gi][0];
                        chk("fixed_out", gi, fo[gi], x.fixed);
                        chk("ovf", gi, 32'(ovf_o[gi]), 32'(x.ovf));
                        chk("nan", gi, 32'(nan_o[gi]), 32'(x.nan));
                        chk("latency", gi, 32'(cyc - x.acc), 32'(x.lat));
                        $display("inst%0d: out %h ovf %b nan %b latency %0d", gi, fo[gi], ovf_o[gi], nan_o[gi], cyc - x.acc);
                     end
                  end else begin
                     chk("hold_fixed", gi, fo[gi], held_f);
                     chk("hold_flags", gi, {30'b0, ovf_o[gi], nan_o[gi]}, {30'b0, held_o, held_n});
                  end
                  chk("in_ready_in_done", gi, 32'(ir[gi]), 32'h0);
                  held_f = fo[gi];
                  held_o = ovf_o[gi];
                  held_n = nan_o[gi];
                  if (out_ready && q[gi].size() != 0) void'(q[gi].pop_front());
                  prev_v = !out_ready;
               end else begin
                  prev_v = 1'b0;
               end
            end
         end
      end
   endgenerate

   initial begin
      logic [15:0] vec[11];
      vec = '{16'h3C00, 16'hBC00, 16'h3555, 16'h0001, 16'h8000, 16'h4000,
              16'hFC00, 16'h7E00, 16'h03FF, 16'h0400, 16'h3BFF};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset_in_ready", i, 32'(ir[i]), 32'h1);
         chk("reset_out_valid", i, 32'(ov[i]), 32'h0);
         chk("reset_fixed", i, fo[i], 32'h0);
      end
      @(negedge clk);

      foreach (vec[i]) begin
         $display("in %h", vec[i]);
         issue(vec[i]);
      end
      drain();

      // Backpressure: results parked in DONE while a new input is offered
      hold = 1'b1;
      issue(16'h3C00);
      begin
         int t = 0;
         while (!(ov[0] && ov[1]) && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (t >= 100) chk("bp_wait_timeout", 0, 32'h1, 32'h0);
      end
      in_valid = 1'b1;
      float_in = 16'h4000;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      hold = 1'b0;
      drain();

      // Reset three edges into a conversion aborts it
      @(negedge clk);
      issue(16'h3C00);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q[0].delete();
      q[1].delete();
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("abort_out_valid", i, 32'(ov[i]), 32'h0);
         chk("abort_fixed", i, fo[i], 32'h0);
         chk("abort_in_ready", i, 32'(ir[i]), 32'h1);
      end
      @(negedge clk);
      issue(16'h3800);
      drain();

      for (int n = 0; n < 200; n++) begin
         logic [15:0] f = 16'($urandom_range(0, 65535));
         $display("in %h", f);
         issue(f);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/float2fix.md
Name: float2fix

Overview:
- Converts an IEEE-754 half-precision value to the 32-bit sign-magnitude fixed-point format used by the ALU datapath.
- Fixed format: bit 31 = sign; bits 30..0 = magnitude; bit 30 has weight 2^0; bit k has weight 2^(k-30). This is Q1.30.
- Sits on the ALU return path and feeds FP16 coefficients and results back into the fixed-point MAC chain.
- Multi-cycle iterative shifter with valid/ready handshakes on both sides.

Parameters:
- SHIFT_STEP, 1, maximum left-shift bits applied per SHIFT cycle. Legal values: 1, 2, 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  float_in is valid
- in_ready  out  1  block can accept an input
- float_in  in  16  FP16 operand: [15] sign, [14:10] biased exponent, [9:0] mantissa
- out_valid  out  1  fixed_out, ovf and nan are valid
- out_ready  in  1  downstream accepts the result
- fixed_out  out  32  converted sign-magnitude Q1.30 value
- ovf  out  1  result saturated (|value| ≥ 2.0 or ±inf)
- nan  out  1  input was NaN

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE.
  - fixed_out = 0, ovf = 0, nan = 0, out_valid = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-SHIFT or mid-DONE aborts the conversion. No result is emitted.
- States: IDLE, SHIFT, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- Accept: in_valid & in_ready at an edge. Let e = float_in[14:10], m = float_in[9:0], s = float_in[15].
  - e = 31, m ≠ 0 (NaN): result = 0x00000000, nan = 1, ovf = 0. Go to DONE.
  - e = 31, m = 0 (inf), or 16 ≤ e ≤ 30: result = {s, 31'h7FFFFFFF}, ovf = 1, nan = 0. Go to DONE.
  - 1 ≤ e ≤ 15: working register = {1'b1, m} placed at bits 16..6, shift count = e − 1. Go to SHIFT.
  - e = 0 (zero/subnormal): working register = m placed at bits 15..6, shift count = 0. Go to SHIFT.
- SHIFT, each edge:
  - If count ≠ 0: shift the register left by min(SHIFT_STEP, count) and decrement count by the same amount.
  - If count = 0: fixed_out = {s', reg[30:0]} with s' = s & (reg ≠ 0). Negative zero is never emitted. ovf = nan = 0. Go to DONE.
- DONE:
  - Outputs are held stable while out_ready = 0.
  - On an edge with out_ready = 1: go to IDLE, out_valid drops.
  - fixed_out keeps its last value after handoff.
- No input is accepted in DONE. Throughput is one conversion per (latency + 1) cycles minimum.
- Latency, counted as edges from accept to out_valid visible:
  - Specials: 1.
  - Normal / subnormal: ceil(count / SHIFT_STEP) + 2.
  - Worst case with SHIFT_STEP = 1: e = 15 gives 16 edges.
- Exactness: all finite inputs with e ≤ 15 convert with no rounding. The smallest LSB (2^-24) lands at bit 6. Bits 5..0 of fixed_out are always 0.
- in_valid while in_ready = 0 is ignored. The upstream side must hold the data.

Decomposition:
- Shared package (alu_pkg) holds:
  - FP16_EXP_W = 5, FP16_MANT_W = 10, FP16_BIAS = 15.
  - FIX_W = 32, FIX_FRAC = 30, FIX_SUBN_LSB = 6, FIX_MAX_EXP = 15.
  - FIX_SAT_MAG = 31'h7FFFFFFF.
  - The state enum {IDLE, SHIFT, DONE}.
- One natural sub-module: fp16_classify, combinational. It takes float_in and outputs is_nan, is_inf, is_ovf, is_sub, and shift count. The FSM and shifter stay in float2fix.

Test Plan:
- 0x3C00 (1.0), out_ready = 1, SHIFT_STEP = 1 → fixed_out = 0x40000000, ovf = 0, nan = 0, out_valid 16 edges after accept. 0xBC00 → 0xC0000000.
- 0x3555 → 0x15540000. 0x0001 → 0x00000040 with latency 2. 0x8000 → 0x00000000, sign bit clear.
- 0x4000 → 0x7FFFFFFF, ovf = 1. 0xFC00 → 0xFFFFFFFF, ovf = 1. 0x7E00 → 0x00000000, nan = 1. Each with latency 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → out_valid and fixed_out stay stable, in_ready = 0, a new in_valid is ignored. Handoff occurs on the first out_ready = 1 edge.
- Reset asserted 3 edges into converting 0x3C00 → next cycle state IDLE, out_valid = 0, fixed_out = 0. A following 0x3800 converts to 0x20000000.
- Re-run the first vector with SHIFT_STEP = 4 → 0x40000000 at ceil(14/4) + 2 = 6 edges after accept.
